// File: rtl/mult_fu_ctrl.sv
// Issue controller and result buffer for a fixed-latency pipelined multiplier.
// Extends operands per RV32M func, shadows the non-stallable multiplier chain
// with a valid/tag/func shift pipe, buffers results until the CDB grants, and
// throttles issue with a credit count covering in-flight plus buffered ops.
module mult_fu_ctrl #(
  parameter int unsigned NUM_STAGE = 4,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned XLEN      = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic [1:0]          issue_func,
  input  logic [XLEN-1:0]     issue_rs1,
  input  logic [XLEN-1:0]     issue_rs2,
  input  logic [TAG_W-1:0]    issue_tag,
  output logic                issue_ready,
  input  logic                squash,
  output logic                mult_start,
  output logic [2*XLEN-1:0]   mult_mcand,
  output logic [2*XLEN-1:0]   mult_mplier,
  input  logic [2*XLEN-1:0]   mult_product,
  output logic                result_valid,
  output logic [XLEN-1:0]     result_data,
  output logic [TAG_W-1:0]    result_tag,
  input  logic                cdb_grant
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

  localparam logic [1:0] FN_MUL    = 2'd0;
  localparam logic [1:0] FN_MULH   = 2'd1;
  localparam logic [1:0] FN_MULHU  = 2'd3;

  // Shift pipe shadowing the multiplier chain
  logic [NUM_STAGE-1:0] r_pv;
  logic [TAG_W-1:0]     r_ptag  [NUM_STAGE];
  logic [1:0]           r_pfunc [NUM_STAGE];

  // Result FIFO storage and pointers (index plus wrap bit)
  logic [XLEN-1:0]  r_mem_data [OUT_DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [OUT_DEPTH];
  logic [PTR_W-1:0] r_wr_idx;
  logic [PTR_W-1:0] r_rd_idx;
  logic             r_wr_wrap;
  logic             r_rd_wrap;

  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [XLEN-1:0]  w_res;

  // Handshake and FIFO status decode
  always_comb begin
    issue_ready  = (r_count < CNT_W'(OUT_DEPTH));
    w_accept     = issue_valid & issue_ready & ~squash;
    mult_start   = w_accept;
    w_empty      = (r_wr_idx == r_rd_idx) & (r_wr_wrap == r_rd_wrap);
    w_full       = (r_wr_idx == r_rd_idx) & (r_wr_wrap != r_rd_wrap);
    result_valid = ~w_empty;
    result_data  = r_mem_data[r_rd_idx];
    result_tag   = r_mem_tag[r_rd_idx];
    w_push       = r_pv[NUM_STAGE-1] & ~squash;
    w_pop        = ~w_empty & cdb_grant & ~squash;
  end

  // Operand extension: rs1 signed unless MULHU, rs2 signed only for MUL/MULH
  always_comb begin
    w_sign_a    = issue_rs1[XLEN-1] & (issue_func != FN_MULHU);
    w_sign_b    = issue_rs2[XLEN-1] & ((issue_func == FN_MUL) | (issue_func == FN_MULH));
    mult_mcand  = {{XLEN{w_sign_a}}, issue_rs1};
    mult_mplier = {{XLEN{w_sign_b}}, issue_rs2};
  end

  // Low half for MUL, high half for the MULH variants
  always_comb begin
    w_res = (r_pfunc[NUM_STAGE-1] == FN_MUL) ? mult_product[XLEN-1:0]
                                             : mult_product[2*XLEN-1:XLEN];
  end

  // Pipe valids: the sole record of which chain slots hold live ops
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv <= '0;
    end else if (squash) begin
      r_pv <= '0;
    end else begin
      r_pv[0] <= w_accept;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_pv[i] <= r_pv[i-1];
      end
    end
  end

  // Pipe tag/func payload travels alongside the valids
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_ptag[i]  <= '0;
        r_pfunc[i] <= '0;
      end
    end else begin
      r_ptag[0]  <= issue_tag;
      r_pfunc[0] <= issue_func;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_ptag[i]  <= r_ptag[i-1];
        r_pfunc[i] <= r_pfunc[i-1];
      end
    end
  end

  // FIFO storage write at the tail
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        r_mem_data[i] <= '0;
        r_mem_tag[i]  <= '0;
      end
    end else if (w_push) begin
      r_mem_data[r_wr_idx] <= w_res;
      r_mem_tag[r_wr_idx]  <= r_ptag[NUM_STAGE-1];
    end
  end

  // FIFO pointers wrap at OUT_DEPTH, toggling the wrap bit
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_idx  <= '0;
      r_wr_wrap <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_wrap <= 1'b0;
    end else if (squash) begin
      r_wr_idx  <= '0;
      r_wr_wrap <= 1'b0;
      r_rd_idx  <= '0;
      r_rd_wrap <= 1'b0;
    end else begin
      if (w_push) begin
        if (r_wr_idx == PTR_W'(OUT_DEPTH - 1)) begin
          r_wr_idx  <= '0;
          r_wr_wrap <= ~r_wr_wrap;
        end else begin
          r_wr_idx <= r_wr_idx + PTR_W'(1);
        end
      end
      if (w_pop) begin
        if (r_rd_idx == PTR_W'(OUT_DEPTH - 1)) begin
          r_rd_idx  <= '0;
          r_rd_wrap <= ~r_rd_wrap;
        end else begin
          r_rd_idx <= r_rd_idx + PTR_W'(1);
        end
      end
    end
  end

  // Credits: in-flight plus buffered ops, no same-cycle pop lookahead
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (squash) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_pop);
    end
  end

  // Credits must keep the FIFO from ever overflowing
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (!(w_push && w_full && !w_pop));
    end
  end

endmodule
